// File: rtl/lavanderia_pkg.sv
// Shared definitions for the laundry machine: phase codes, wash type
// codes and the per-type phase duration table (in 1 s ticks).
package lavanderia_pkg;

   localparam logic [2:0] LIVRE       = 3'd0;
   localparam logic [2:0] ENCHER      = 3'd1;
   localparam logic [2:0] LAVAR       = 3'd2;
   localparam logic [2:0] ENXAGUAR    = 3'd3;
   localparam logic [2:0] CENTRIFUGAR = 3'd4;
   localparam logic [2:0] FIM         = 3'd5;

   localparam logic [1:0] TIPO_RAPIDA  = 2'b00;
   localparam logic [1:0] TIPO_NORMAL  = 2'b01;
   localparam logic [1:0] TIPO_PESADA  = 2'b10;
   localparam logic [1:0] TIPO_INVALID = 2'b11;

   // Duration of LAVAR/ENXAGUAR/CENTRIFUGAR for a given wash type.
   // ENCHER is the same for every type and comes from a parameter.
   function automatic logic [7:0] dur(input logic [1:0] t,
                                      input logic [2:0] f);
      logic [7:0] d;
      d = 8'd0;
      case (f)
         LAVAR: begin
            case (t)
               TIPO_RAPIDA: d = 8'd10;
               TIPO_NORMAL: d = 8'd20;
               TIPO_PESADA: d = 8'd30;
               default:     d = 8'd0;
            endcase
         end
         ENXAGUAR: begin
            case (t)
               TIPO_RAPIDA: d = 8'd5;
               TIPO_NORMAL: d = 8'd10;
               TIPO_PESADA: d = 8'd15;
               default:     d = 8'd0;
            endcase
         end
         CENTRIFUGAR: begin
            case (t)
               TIPO_RAPIDA: d = 8'd5;
               TIPO_NORMAL: d = 8'd8;
               TIPO_PESADA: d = 8'd12;
               default:     d = 8'd0;
            endcase
         end
         default: d = 8'd0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/gerador_tick.sv
// Prescaler producing a 1-cycle tick every TICK_DIV clocks.
// Ports: clk, reset (async active-low), clr (restart at 0),
// freeze (only with LAVANDERIA_PAUSA_EN: hold count), tick (out).
module gerador_tick #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
`ifdef LAVANDERIA_PAUSA_EN
   input  logic freeze,
`endif
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          hold;

`ifdef LAVANDERIA_PAUSA_EN
   assign hold = freeze;
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (!hold) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/maquina_lavagem.sv
// Washing machine responder: accepts a release request and runs the
// timed cycle ENCHER->LAVAR->ENXAGUAR->CENTRIFUGAR->FIM.
// Ports: clk, reset (async active-low), libera, tipo[1:0], cancela in;
// aceito, erro, fim pulses, ocupada, fase[2:0], tempo_restante[7:0] out.
// LAVANDERIA_PAUSA_EN adds porta_aberta (in) and pausada (out).
module maquina_lavagem
   import lavanderia_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int T_ENCHER = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       libera,
   input  logic [1:0] tipo,
   input  logic       cancela,
`ifdef LAVANDERIA_PAUSA_EN
   input  logic       porta_aberta,
   output logic       pausada,
`endif
   output logic       aceito,
   output logic       erro,
   output logic       ocupada,
   output logic       fim,
   output logic [2:0] fase,
   output logic [7:0] tempo_restante
);

   logic [2:0] fase_q, fase_d;
   logic [1:0] tipo_q, tipo_d;
   logic [7:0] tempo_q, tempo_d;
   logic       aceito_q, aceito_d;
   logic       erro_q, erro_d;
   logic       fim_q, fim_d;
   logic       clr;
   logic       tick;
   logic       porta;
   logic       ativo;
   logic [2:0] prox;

`ifdef LAVANDERIA_PAUSA_EN
   assign porta = porta_aberta;
`else
   assign porta = 1'b0;
`endif

   assign ativo = (fase_q >= ENCHER) && (fase_q <= CENTRIFUGAR);
   assign prox  = fase_q + 3'd1;

   gerador_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
`ifdef LAVANDERIA_PAUSA_EN
      .freeze (ativo && porta),
`endif
      .tick   (tick)
   );

   always_comb begin
      fase_d   = fase_q;
      tipo_d   = tipo_q;
      tempo_d  = tempo_q;
      aceito_d = 1'b0;
      erro_d   = 1'b0;
      fim_d    = 1'b0;
      clr      = 1'b0;
      case (fase_q)
         LIVRE: begin
            // Prescaler held at 0 so ENCHER starts on a full tick.
            clr = 1'b1;
            if (libera && !porta) begin
               if (tipo == TIPO_INVALID) begin
                  erro_d = 1'b1;
               end else begin
                  tipo_d   = tipo;
                  fase_d   = ENCHER;
                  tempo_d  = 8'(T_ENCHER);
                  aceito_d = 1'b1;
               end
            end
         end
         ENCHER, LAVAR, ENXAGUAR, CENTRIFUGAR: begin
            if (cancela) begin
               fase_d  = FIM;
               tempo_d = 8'd0;
               fim_d   = 1'b1;
               clr     = 1'b1;
            end else if (tick) begin
               if (tempo_q == 8'd1) begin
                  fase_d = prox;
                  if (prox == FIM) begin
                     tempo_d = 8'd0;
                     fim_d   = 1'b1;
                  end else begin
                     tempo_d = dur(tipo_q, prox);
                  end
               end else begin
                  tempo_d = tempo_q - 8'd1;
               end
            end
         end
         FIM: begin
            fase_d  = LIVRE;
            tempo_d = 8'd0;
            clr     = 1'b1;
         end
         default: begin
            fase_d  = LIVRE;
            tempo_d = 8'd0;
            clr     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fase_q   <= LIVRE;
         tipo_q   <= TIPO_RAPIDA;
         tempo_q  <= 8'd0;
         aceito_q <= 1'b0;
         erro_q   <= 1'b0;
         fim_q    <= 1'b0;
      end else begin
         fase_q   <= fase_d;
         tipo_q   <= tipo_d;
         tempo_q  <= tempo_d;
         aceito_q <= aceito_d;
         erro_q   <= erro_d;
         fim_q    <= fim_d;
      end
   end

   assign fase           = fase_q;
   assign tempo_restante = tempo_q;
   assign aceito         = aceito_q;
   assign erro           = erro_q;
   assign fim            = fim_q;
   assign ocupada        = (fase_q != LIVRE);

`ifdef LAVANDERIA_PAUSA_EN
   assign pausada = ativo && porta;
`endif

endmodule

// File: tb/tb_maquina_lavagem.sv
// Bench for maquina_lavagem: directed scenarios plus random traffic
// compared cycle by cycle against a timeline model of the wash cycle.
module tb_maquina_lavagem;

   localparam int TD = 4;
   localparam int TE = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       libera = 1'b0;
   logic [1:0] tipo = 2'b00;
   logic       cancela = 1'b0;
   logic       aceito, erro, ocupada, fim;
   logic [2:0] fase;
   logic [7:0] tempo_restante;
`ifdef LAVANDERIA_PAUSA_EN
   logic       porta_aberta = 1'b0;
   logic       pausada;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // Model: 0 idle, 1 running (k = active cycles since accept), 2 fim
   int         m_mode = 0;
   int         m_k = 0;
   logic [1:0] m_tipo = 2'b00;
   bit         e_ac = 0;
   bit         e_er = 0;
   int         lav[3] = '{10, 20, 30};
   int         enx[3] = '{5, 10, 15};
   int         cen[3] = '{5, 8, 12};

   always #5 clk = ~clk;

   maquina_lavagem #(
      .TICK_DIV (TD),
      .T_ENCHER (TE)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .libera         (libera),
      .tipo           (tipo),
      .cancela        (cancela),
`ifdef LAVANDERIA_PAUSA_EN
      .porta_aberta   (porta_aberta),
      .pausada        (pausada),
`endif
      .aceito         (aceito),
      .erro           (erro),
      .ocupada        (ocupada),
      .fim            (fim),
      .fase           (fase),
      .tempo_restante (tempo_restante)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
      end
   endtask

   function automatic bit porta_now();
`ifdef LAVANDERIA_PAUSA_EN
      return porta_aberta;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int total(input logic [1:0] t);
      return (TE + lav[t] + enx[t] + cen[t]) * TD;
   endfunction

   // Phase and remaining ticks after k active cycles of a run
   task automatic exp_run(input int k, input logic [1:0] t,
                          output int f, output int tr);
      int d[4];
      int base;
      d[0] = TE;
      d[1] = lav[t];
      d[2] = enx[t];
      d[3] = cen[t];
      base = 0;
      f = 5;
      tr = 0;
      for (int i = 0; i < 4; i++) begin
         if (f == 5 && k < base + d[i] * TD) begin
            f = i + 1;
            tr = d[i] - (k - base) / TD;
         end
         base += d[i] * TD;
      end
   endtask

   task automatic predict();
      e_ac = 0;
      e_er = 0;
      if (!reset) begin
         m_mode = 0;
         return;
      end
      case (m_mode)
         0: begin
            if (libera && !porta_now()) begin
               if (tipo == 2'b11) begin
                  e_er = 1;
               end else begin
                  m_mode = 1;
                  m_k = 0;
                  m_tipo = tipo;
                  e_ac = 1;
               end
            end
         end
         1: begin
            if (cancela) begin
               m_mode = 2;
            end else if (!porta_now()) begin
               m_k++;
               if (m_k == total(m_tipo)) m_mode = 2;
            end
         end
         default: m_mode = 0;
      endcase
   endtask

   task automatic check_all();
      int ef, et;
      ef = 0;
      et = 0;
      if (m_mode == 1) exp_run(m_k, m_tipo, ef, et);
      else if (m_mode == 2) ef = 5;
      chk("fase", int'(fase), ef);
      chk("tempo", int'(tempo_restante), et);
      chk("aceito", int'(aceito), int'(e_ac));
      chk("erro", int'(erro), int'(e_er));
      chk("fim", int'(fim), int'(m_mode == 2));
      chk("ocupada", int'(ocupada), int'(m_mode != 0));
`ifdef LAVANDERIA_PAUSA_EN
      chk("pausada", int'(pausada), int'(m_mode == 1 && porta_aberta));
`endif
   endtask

   task automatic step();
      predict();
      @(posedge clk);
      #1;
      cyc++;
      check_all();
   endtask

   initial begin
      int ac_cyc;
      int cnt[8];
      int t0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 1'b1;
      step();

      // 1: rapida full cycle, phase lengths and fim latency
      foreach (cnt[i]) cnt[i] = 0;
      libera = 1'b1;
      tipo = 2'b00;
      step();
      chk("s1_aceito", int'(aceito), 1);
      ac_cyc = cyc;
      libera = 1'b0;
      cnt[fase]++;
      for (int i = 0; i < 200 && !fim; i++) begin
         step();
         cnt[fase]++;
      end
      chk("s1_fim_lat", cyc - ac_cyc, 88);
      chk("s1_n_encher", cnt[1], 8);
      chk("s1_n_lavar", cnt[2], 40);
      chk("s1_n_enxag", cnt[3], 20);
      chk("s1_n_centr", cnt[4], 20);
      step();
      chk("s1_livre", int'(fase), 0);
      chk("s1_ocupada", int'(ocupada), 0);

      // 2: invalid tipo
      libera = 1'b1;
      tipo = 2'b11;
      step();
      chk("s2_erro", int'(erro), 1);
      chk("s2_aceito", int'(aceito), 0);
      chk("s2_fase", int'(fase), 0);
      libera = 1'b0;
      step();
      chk("s2_erro_off", int'(erro), 0);

      // 3: pesada, re-pulsed libera ignored during LAVAR
      libera = 1'b1;
      tipo = 2'b10;
      step();
      libera = 1'b0;
      for (int i = 0; i < 100 && fase != 3'd2; i++) step();
      chk("s3_lav_entry", int'(tempo_restante), 30);
      libera = 1'b1;
      tipo = 2'b00;
      repeat (4) step();
      chk("s3_lav_after4", int'(tempo_restante), 29);
      chk("s3_still_lav", int'(fase), 2);
      libera = 1'b0;
      cancela = 1'b1;
      step();
      cancela = 1'b0;
      step();

      // 4: cancel during ENXAGUAR
      libera = 1'b1;
      tipo = 2'b00;
      step();
      libera = 1'b0;
      for (int i = 0; i < 200 && fase != 3'd3; i++) step();
      chk("s4_reach_enx", int'(fase), 3);
      cancela = 1'b1;
      step();
      chk("s4_fase_fim", int'(fase), 5);
      chk("s4_fim", int'(fim), 1);
      cancela = 1'b0;
      step();
      chk("s4_livre", int'(fase), 0);

      // 5: asynchronous reset mid-LAVAR
      libera = 1'b1;
      tipo = 2'b01;
      step();
      libera = 1'b0;
      for (int i = 0; i < 200 && fase != 3'd2; i++) step();
      chk("s5_reach_lav", int'(fase), 2);
      repeat (3) step();
      #3;
      reset = 1'b0;
      #1;
      m_mode = 0;
      e_ac = 0;
      e_er = 0;
      check_all();
      step();
      step();
      reset = 1'b1;
      step();
      libera = 1'b1;
      tipo = 2'b01;
      step();
      chk("s5_reaccept", int'(aceito), 1);
      libera = 1'b0;
      cancela = 1'b1;
      step();
      cancela = 1'b0;
      step();

`ifdef LAVANDERIA_PAUSA_EN
      // 6: door open for 10 cycles in LAVAR delays fim by 10
      libera = 1'b1;
      tipo = 2'b00;
      step();
      ac_cyc = cyc;
      libera = 1'b0;
      for (int i = 0; i < 200 && fase != 3'd2; i++) step();
      repeat (3) step();
      t0 = int'(tempo_restante);
      porta_aberta = 1'b1;
      repeat (10) step();
      chk("s6_pausada", int'(pausada), 1);
      chk("s6_tempo_hold", int'(tempo_restante), t0);
      porta_aberta = 1'b0;
      for (int i = 0; i < 300 && !fim; i++) step();
      chk("s6_fim_lat", cyc - ac_cyc, 98);
      step();
`else
      t0 = 0;
`endif

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         libera = ($urandom_range(0, 3) == 0);
         tipo = 2'($urandom_range(0, 3));
         cancela = ($urandom_range(0, 79) == 0);
`ifdef LAVANDERIA_PAUSA_EN
         porta_aberta = ($urandom_range(0, 15) == 0);
`endif
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
